// File: rtl/dmem_pkg.sv
// Shared owner, state and write-enable encodings for the data-BRAM port-B arbiter.
package dmem_pkg;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DBG = 1'b1;

  typedef enum logic {
    StArb    = 1'b0,
    StLocked = 1'b1
  } arb_state_e;

  localparam logic [3:0] WE_READ = 4'b0000;

  function automatic logic is_read(input logic [3:0] we);
    return we == WE_READ;
  endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// Tracks in-flight BRAM reads: a Depth-stage valid+owner shift register that
// presents each tag exactly Depth cycles after it was pushed.
module rd_tag_pipe #(
  parameter int unsigned Depth = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  logic owner_i,
  output logic valid_o,
  output logic owner_o
);

  logic [Depth-1:0] valid_q, valid_d;
  logic [Depth-1:0] owner_q, owner_d;

  always_comb begin
    valid_d    = valid_q;
    owner_d    = owner_q;
    valid_d[0] = push_i;
    owner_d[0] = owner_i;
    for (int unsigned i = 1; i < Depth; i++) begin
      valid_d[i] = valid_q[i-1];
      owner_d[i] = owner_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      owner_q <= '0;
    end else begin
      valid_q <= valid_d;
      owner_q <= owner_d;
    end
  end

  assign valid_o = valid_q[Depth-1];
  assign owner_o = owner_q[Depth-1];

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares data-BRAM port B between the CPU and the UART loader: round-robin grant,
// loader lock for burst downloads, and read-return routing to the issuing requester.
module dmem_port_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req_i,
  input  logic [3:0]        cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  output logic              cpu_gnt_o,
  output logic              cpu_rvalid_o,
  output logic [31:0]       cpu_rdata_o,
  input  logic              dbg_req_i,
  input  logic              dbg_lock_i,
  input  logic [3:0]        dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [31:0]       dbg_wdata_i,
  output logic              dbg_gnt_o,
  output logic              dbg_rvalid_o,
  output logic [31:0]       dbg_rdata_o,
  output logic              enb_o,
  output logic [3:0]        web_o,
  output logic [ADDR_W-1:0] addrb_o,
  output logic [31:0]       dib_o,
  input  logic [31:0]       dob_i
);

  arb_state_e state_q, state_d;
  logic       last_gnt_q, last_gnt_d;
  logic       cpu_gnt, dbg_gnt;
  logic       rd_push, rd_valid, rd_owner;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StArb;
      last_gnt_q <= OWNER_DBG;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  // Grants are gated by rst_n so every output is quiet while reset is held.
  always_comb begin
    cpu_gnt    = 1'b0;
    dbg_gnt    = 1'b0;
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    if (rst_n) begin
      unique case (state_q)
        StArb: begin
          if (cpu_req_i && dbg_req_i) begin
            if (last_gnt_q == OWNER_DBG) cpu_gnt = 1'b1;
            else                         dbg_gnt = 1'b1;
          end else begin
            cpu_gnt = cpu_req_i;
            dbg_gnt = dbg_req_i;
          end
          if (dbg_gnt && dbg_lock_i) state_d = StLocked;
        end
        StLocked: begin
          dbg_gnt = dbg_req_i;
          if (!dbg_lock_i) state_d = StArb;
        end
      endcase
      if (cpu_gnt)      last_gnt_d = OWNER_CPU;
      else if (dbg_gnt) last_gnt_d = OWNER_DBG;
    end
  end

  always_comb begin
    enb_o   = 1'b0;
    web_o   = '0;
    addrb_o = '0;
    dib_o   = '0;
    if (cpu_gnt) begin
      enb_o   = 1'b1;
      web_o   = cpu_we_i;
      addrb_o = cpu_addr_i;
      dib_o   = cpu_wdata_i;
    end else if (dbg_gnt) begin
      enb_o   = 1'b1;
      web_o   = dbg_we_i;
      addrb_o = dbg_addr_i;
      dib_o   = dbg_wdata_i;
    end
  end

  assign rd_push = (cpu_gnt && is_read(cpu_we_i)) || (dbg_gnt && is_read(dbg_we_i));

  rd_tag_pipe #(
    .Depth (RD_LAT)
  ) u_rd_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rd_push),
    .owner_i (dbg_gnt ? OWNER_DBG : OWNER_CPU),
    .valid_o (rd_valid),
    .owner_o (rd_owner)
  );

  assign cpu_gnt_o    = cpu_gnt;
  assign dbg_gnt_o    = dbg_gnt;
  assign cpu_rvalid_o = rd_valid && (rd_owner == OWNER_CPU);
  assign dbg_rvalid_o = rd_valid && (rd_owner == OWNER_DBG);
  assign cpu_rdata_o  = cpu_rvalid_o ? dob_i : '0;
  assign dbg_rdata_o  = dbg_rvalid_o ? dob_i : '0;

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares data-BRAM port B between the CPU load/store path and the UART debug/program loader.
- Each cycle it grants at most one requester and drives the BRAM enable, byte-enables, address and write data.
- It tracks in-flight reads through the BRAM read latency so each read's return data goes back to the requester that issued it.
- A lock input lets the loader hold the port for back-to-back burst writes during program download.

Parameters:
- ADDR_W, 32, address width passed through to addrb.
- RD_LAT, 1, BRAM read latency in cycles. Legal range is 1..4.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU access request, held until granted.
- cpu_we  in  4  CPU byte write enables. 0000 means read.
- cpu_addr  in  ADDR_W  CPU byte address.
- cpu_wdata  in  32  CPU write data, already lane-aligned.
- cpu_gnt  out  1  CPU request accepted this cycle.
- cpu_rvalid  out  1  CPU read data valid.
- cpu_rdata  out  32  CPU read data.
- dbg_req  in  1  loader access request.
- dbg_lock  in  1  loader requests to keep ownership after its grant.
- dbg_we  in  4  loader byte write enables.
- dbg_addr  in  ADDR_W  loader byte address.
- dbg_wdata  in  32  loader write data.
- dbg_gnt  out  1  loader request accepted this cycle.
- dbg_rvalid  out  1  loader read data valid.
- dbg_rdata  out  32  loader read data.
- enb  out  1  BRAM port B enable.
- web  out  4  BRAM port B byte write enables.
- addrb  out  ADDR_W  BRAM port B address.
- dib  out  32  BRAM port B write data.
- dob  in  32  BRAM port B read data.

Behaviour:
- Reset: clk and rst_n form the only clock/reset pair. Reset is asynchronous and active-low.
  - State goes to ARB and last_gnt goes to DBG, so the CPU wins the first tie.
  - The response pipeline is cleared.
  - All outputs are 0 while rst_n is low.
- Grant (combinational from the request inputs and registered state):
  - At most one of cpu_gnt and dbg_gnt is 1 in any cycle.
  - A granted access drives enb=1, web=we, addrb=addr and wdata onto dib in the same cycle.
  - With no grant: enb=0, web=0, addrb=0, dib=0.
- State ARB:
  - Only one requester asserting req: that requester is granted.
  - Both asserting req: the requester that is not last_gnt is granted (round-robin).
  - last_gnt updates on every grant.
  - Transition to LOCKED when dbg_gnt=1 and dbg_lock=1 in the same cycle.
- State LOCKED:
  - cpu_gnt is forced to 0.
  - dbg_req is granted whenever asserted.
  - Transition to ARB at the first clock edge where dbg_lock=0, whether or not dbg_req is high. The exit edge may coincide with a final granted dbg access.
- Read tracking:
  - A grant with we=0000 is a read.
  - Each read pushes {valid, owner} into an RD_LAT-deep shift register.
  - Exactly RD_LAT cycles after the grant, the owner's rvalid=1 and its rdata=dob.
  - A non-owner's rdata is 0. rdata is 0 whenever rvalid=0.
  - Writes produce no rvalid.
  - Back-to-back reads from alternating owners return in issue order, one per cycle, each to the correct owner.
- Arbitration never stalls a response: responses continue while ownership changes or the lock is taken.
- Requesters must hold req, we, addr and wdata stable until gnt. Changing them while ungranted is a requester error.
- Reset asserted mid-operation: in-flight reads are dropped, no rvalid is produced for them, and the lock is released.
- Partial web values such as 0010 pass through unchanged. The arbiter does not check alignment.

Decomposition:
- Shared package (dmem_pkg):
  - OWNER_CPU=0 and OWNER_DBG=1.
  - The state encoding (ARB=0, LOCKED=1).
  - WE_READ=4'b0000.
- One sub-module, rd_tag_pipe: an RD_LAT-deep valid+owner shift register with synchronous push and asynchronous clear.

Test Plan:
1. Reset check: hold rst_n=0 with cpu_req=1 -> all outputs 0. Release rst_n -> first cycle cpu_gnt=1, enb=1, addrb=cpu_addr.
2. Contention: both requesters assert req for 4 consecutive cycles, each re-requesting immediately -> grant order CPU, DBG, CPU, DBG.
3. CPU read: read at 0x0000_0010 with dob=0xDEADBEEF -> cpu_rvalid=1 exactly RD_LAT cycles later with cpu_rdata=0xDEADBEEF, and dbg_rvalid=0.
4. Loader lock: dbg_lock=1 with 3 dbg writes (we=1111) while cpu_req=1 -> cpu_gnt=0 during all 3. After dbg_lock drops, cpu_gnt=1 on the next cycle.
5. Interleaved reads (RD_LAT=2): CPU read then DBG read on consecutive cycles -> cpu_rvalid at t+2 and dbg_rvalid at t+3, each with the matching dob.
6. Reset mid-read: pulse rst_n low one cycle after a granted read -> no rvalid ever appears for that read, and the state returns to ARB.
